uart_tx_streamer: RTL and testbench

- Transmit-side controller that feeds the UART sender.
- Buffers processed image bytes in a FIFO, prefixes each frame with a header byte, and drives the sender's start/data/busy handshake one byte at a time.
- Sits between the image-processing datapath (byte writer) and the Sender instance in the top level.
- Counterpart of the receive path: it is the writer into the sender interface.

---
 rtl/uart_pkg.sv | 8 +
 rtl/byte_fifo.sv | 68 ++++++
 rtl/uart_tx_streamer.sv | 118 +++++++++++
 tb/tb_uart_tx_streamer.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Types and constants shared by the UART transmit and receive paths.
package uart_pkg;

    typedef enum logic [1:0] {IDLE, START, WAIT_ACK, WAIT_DONE} tx_state_t;

    localparam byte HDR_DEFAULT = 8'hAA;

endpackage

// File: rtl/byte_fifo.sv
// Synchronous byte FIFO with a head-of-queue read port and a sticky overflow flag.
module byte_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push_i,
    input  logic [7:0]             data_i,
    input  logic                   pop_i,
    output logic [7:0]             data_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   overflow_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [7:0]       mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             overflow_q;
    logic             do_push;
    logic             do_pop;

    assign full_o     = (count_q == CNT_W'(DEPTH));
    assign empty_o    = (count_q == '0);
    assign count_o    = count_q;
    assign overflow_o = overflow_q;
    assign data_o     = mem_q[rd_ptr_q];

    // A pop in the same cycle frees the slot a push into a full FIFO needs.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    // NOTE: the storage array is reset too, so every flop in the block has a defined value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 8'h00;
            end
        end else if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    // NOTE: non-blocking assignments keep every flop sampling the pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
            if (push_i && full_o && !do_pop) overflow_q <= 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_streamer.sv
// Streams FIFO-buffered bytes to the UART sender one at a time, prefixing each
// frame with a header byte and re-pulsing start when the sender fails to ack.
module uart_tx_streamer
    import uart_pkg::*;
#(
    parameter int         DEPTH       = 16,
    parameter int         FRAME_LEN   = 64,
    parameter logic [7:0] HEADER      = HDR_DEFAULT,
    parameter bit         HEADER_EN   = 1'b1,
    parameter int         ACK_TIMEOUT = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wr_en,
    input  logic [7:0]             wr_data,
    output logic                   full,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   tx_start,
    output logic [7:0]             tx_data,
    input  logic                   tx_busy,
    output logic                   frame_done,
    output logic                   overflow
);

    localparam int CNT_W = $clog2(FRAME_LEN + 1);
    localparam int TMO_W = $clog2(ACK_TIMEOUT + 1);

    tx_state_t        state_q;
    logic [7:0]       tx_data_q;
    logic             tx_start_q;
    logic             frame_done_q;
    logic             is_hdr_q;
    logic             hdr_sent_q;
    logic [CNT_W-1:0] byte_cnt_q;
    logic [TMO_W-1:0] tmo_q;

    logic             fifo_empty;
    logic [7:0]       fifo_head;
    logic             send_hdr;
    logic             pop;

    // hdr_sent_q stops the header from repeating while byte_cnt is still 0.
    assign send_hdr = HEADER_EN && (byte_cnt_q == '0) && !hdr_sent_q;
    assign pop      = (state_q == IDLE) && !fifo_empty && !send_hdr;

    byte_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push_i     (wr_en),
        .data_i     (wr_data),
        .pop_i      (pop),
        .data_o     (fifo_head),
        .full_o     (full),
        .empty_o    (fifo_empty),
        .count_o    (fifo_count),
        .overflow_o (overflow)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            tx_data_q    <= 8'h00;
            tx_start_q   <= 1'b0;
            frame_done_q <= 1'b0;
            is_hdr_q     <= 1'b0;
            hdr_sent_q   <= 1'b0;
            byte_cnt_q   <= '0;
            tmo_q        <= '0;
        end else begin
            tx_start_q   <= 1'b0;
            frame_done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (!fifo_empty) begin
                        state_q    <= START;
                        tx_start_q <= 1'b1;
                        is_hdr_q   <= send_hdr;
                        tx_data_q  <= send_hdr ? HEADER : fifo_head;
                    end
                end
                START: begin
                    tmo_q   <= '0;
                    state_q <= WAIT_ACK;
                end
                WAIT_ACK: begin
                    if (tx_busy) begin
                        state_q <= WAIT_DONE;
                    end else if (tmo_q == TMO_W'(ACK_TIMEOUT - 1)) begin
                        state_q    <= START;
                        tx_start_q <= 1'b1;
                    end else begin
                        tmo_q <= tmo_q + TMO_W'(1);
                    end
                end
                WAIT_DONE: begin
                    if (!tx_busy) begin
                        state_q <= IDLE;
                        if (is_hdr_q) begin
                            hdr_sent_q <= 1'b1;
                        end else if (byte_cnt_q == CNT_W'(FRAME_LEN - 1)) begin
                            byte_cnt_q   <= '0;
                            hdr_sent_q   <= 1'b0;
                            frame_done_q <= 1'b1;
                        end else begin
                            byte_cnt_q <= byte_cnt_q + CNT_W'(1);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign tx_start   = tx_start_q;
    assign tx_data    = tx_data_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_uart_tx_streamer.sv
// Directed bench: header framing, raw-mode latency, FIFO full/overflow,
// ack timeout re-pulse, async reset mid-transfer and two-frame streaming.
module tb_uart_tx_streamer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       wr_en_a = 1'b0, wr_en_b = 1'b0;
    logic [7:0] wr_data_a = 8'h00, wr_data_b = 8'h00;
    logic       full_a, full_b;
    logic [2:0] fifo_count_a, fifo_count_b;
    logic       tx_start_a, tx_start_b;
    logic [7:0] tx_data_a, tx_data_b;
    logic       tx_busy_a;
    logic       tx_busy_b = 1'b0;
    logic       frame_done_a, frame_done_b;
    logic       overflow_a, overflow_b;

    // Sender model controls
    logic sender_en = 1'b0;
    logic hold_busy = 1'b0;
    logic model_busy = 1'b0;
    assign tx_busy_a = model_busy | hold_busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int frames = 0;
    logic [7:0] st_data[$];
    int         st_cyc[$];

    always #5 clk = ~clk;

    uart_tx_streamer #(.DEPTH(4), .FRAME_LEN(2), .HEADER(8'hAA), .HEADER_EN(1'b1), .ACK_TIMEOUT(8)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en_a), .wr_data(wr_data_a), .full(full_a),
        .fifo_count(fifo_count_a), .tx_start(tx_start_a), .tx_data(tx_data_a), .tx_busy(tx_busy_a),
        .frame_done(frame_done_a), .overflow(overflow_a)
    );

    uart_tx_streamer #(.DEPTH(4), .FRAME_LEN(2), .HEADER(8'hAA), .HEADER_EN(1'b0), .ACK_TIMEOUT(8)) dut_raw (
        .clk(clk), .reset(reset), .wr_en(wr_en_b), .wr_data(wr_data_b), .full(full_b),
        .fifo_count(fifo_count_b), .tx_start(tx_start_b), .tx_data(tx_data_b), .tx_busy(tx_busy_b),
        .frame_done(frame_done_b), .overflow(overflow_b)
    );

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (tx_start_a) begin
            st_data.push_back(tx_data_a);
            st_cyc.push_back(cyc);
        end
        if (frame_done_a) frames <= frames + 1;
    end

    // Sender: busy rises 2 cycles after an accepted start and stays high 10 cycles.
    initial begin
        forever begin
            @(negedge clk);
            if (sender_en && tx_start_a) begin
                repeat (2) @(negedge clk);
                model_busy = 1'b1;
                repeat (10) @(negedge clk);
                model_busy = 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic write_a(input logic [7:0] d);
        wr_en_a = 1'b1;
        wr_data_a = d;
        step(1);
        wr_en_a = 1'b0;
    endtask

    task automatic wait_starts(input int n, input string tag);
        int budget = 400;
        while (st_data.size() < n && budget > 0) begin
            step(1);
            budget--;
        end
        check(tag, 32'(st_data.size() >= n), 32'd1);
    endtask

    task automatic clear_log();
        st_data.delete();
        st_cyc.delete();
        frames = 0;
    endtask

    task automatic check_seq(input string tag, input logic [7:0] exp[$]);
        check({tag, "_len"}, 32'(st_data.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < st_data.size(); i++) begin
            check($sformatf("%s_%0d", tag, i), 32'(st_data[i]), 32'(exp[i]));
        end
    endtask

    initial begin
        // Reset values
        #2;
        check("rst_full", 32'(full_a), 32'd0);
        check("rst_count", 32'(fifo_count_a), 32'd0);
        check("rst_start", 32'(tx_start_a), 32'd0);
        check("rst_data", 32'(tx_data_a), 32'h00);
        check("rst_frame", 32'(frame_done_a), 32'd0);
        check("rst_ovf", 32'(overflow_a), 32'd0);
        step(2);
        reset = 1'b0;
        step(1);

        // Header framing: AA, 11, 22, one frame_done
        sender_en = 1'b1;
        clear_log();
        write_a(8'h11);
        write_a(8'h22);
        wait_starts(3, "hdr_wait");
        step(20);
        check_seq("hdr_seq", '{8'hAA, 8'h11, 8'h22});
        check("hdr_frames", 32'(frames), 32'd1);

        // Raw mode: tx_start exactly two cycles after the write
        wr_en_b = 1'b1;
        wr_data_b = 8'h5A;
        step(1);
        wr_en_b = 1'b0;
        check("raw_start_p1", 32'(tx_start_b), 32'd0);
        step(1);
        check("raw_start_p2", 32'(tx_start_b), 32'd1);
        check("raw_data", 32'(tx_data_b), 32'h5A);
        step(1);
        check("raw_start_p3", 32'(tx_start_b), 32'd0);

        // Fill with sender held busy (header parked in WAIT_DONE)
        sender_en = 1'b0;
        hold_busy = 1'b1;
        write_a(8'h31);
        write_a(8'h32);
        write_a(8'h33);
        write_a(8'h34);
        step(2);
        check("fill_full", 32'(full_a), 32'd1);
        check("fill_count", 32'(fifo_count_a), 32'd4);
        check("fill_ovf", 32'(overflow_a), 32'd0);
        // Release busy for one cycle: header completes, next cycle pops while we push
        hold_busy = 1'b0;
        step(1);
        hold_busy = 1'b1;
        write_a(8'h36);
        check("pop_push_count", 32'(fifo_count_a), 32'd4);
        check("pop_push_full", 32'(full_a), 32'd1);
        check("pop_push_ovf", 32'(overflow_a), 32'd0);
        step(3);
        write_a(8'h37);
        check("ovf_set", 32'(overflow_a), 32'd1);
        check("ovf_count", 32'(fifo_count_a), 32'd4);

        // Drain: 31 is in flight; remaining order 32, AA, 33, 34, AA, 36
        clear_log();
        sender_en = 1'b1;
        hold_busy = 1'b0;
        wait_starts(6, "drain_wait");
        step(20);
        check_seq("drain_seq", '{8'h32, 8'hAA, 8'h33, 8'h34, 8'hAA, 8'h36});
        check("drain_frames", 32'(frames), 32'd2);
        check("drain_empty", 32'(fifo_count_a), 32'd0);
        check("ovf_sticky", 32'(overflow_a), 32'd1);

        // Ack timeout: re-pulse every ACK_TIMEOUT+1 cycles with the same byte
        sender_en = 1'b0;
        clear_log();
        write_a(8'h77);
        wait_starts(3, "tmo_wait");
        check("tmo_gap1", 32'(st_cyc[1] - st_cyc[0]), 32'd9);
        check("tmo_gap2", 32'(st_cyc[2] - st_cyc[1]), 32'd9);
        sender_en = 1'b1;
        wait_starts(4, "tmo_ack_wait");
        step(20);
        for (int i = 0; i < st_data.size(); i++) begin
            check($sformatf("tmo_data_%0d", i), 32'(st_data[i]), 32'h77);
        end
        check("tmo_frames", 32'(frames), 32'd1);
        check("tmo_empty", 32'(fifo_count_a), 32'd0);

        // Async reset during WAIT_DONE of payload byte 3
        clear_log();
        write_a(8'h41);
        write_a(8'h42);
        write_a(8'h43);
        wait_starts(5, "mid_wait");
        step(5);
        check("mid_busy", 32'(tx_busy_a), 32'd1);
        check("mid_data", 32'(tx_data_a), 32'h43);
        reset = 1'b1;
        #1;
        check("arst_data", 32'(tx_data_a), 32'h00);
        check("arst_start", 32'(tx_start_a), 32'd0);
        check("arst_count", 32'(fifo_count_a), 32'd0);
        check("arst_full", 32'(full_a), 32'd0);
        check("arst_ovf", 32'(overflow_a), 32'd0);
        check("arst_frame", 32'(frame_done_a), 32'd0);
        step(15);
        reset = 1'b0;
        step(1);
        clear_log();
        write_a(8'h01);
        wait_starts(2, "post_rst_wait");
        step(20);
        check_seq("post_rst_seq", '{8'hAA, 8'h01});

        // Two full frames from a clean start
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        step(1);
        clear_log();
        write_a(8'h51);
        write_a(8'h52);
        write_a(8'h53);
        write_a(8'h54);
        wait_starts(6, "stream_wait");
        step(20);
        check_seq("stream_seq", '{8'hAA, 8'h51, 8'h52, 8'hAA, 8'h53, 8'h54});
        check("stream_frames", 32'(frames), 32'd2);
        check("stream_ovf", 32'(overflow_a), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
